// File: rtl/svm_modality_scheduler.sv
// rtl/svm_modality_scheduler.sv - issues buffered valence then arousal vectors to a shared SVM and returns the joint result
// Optional WAIT_RES watchdog: define SVM_TIMEOUT_EN.
module svm_modality_scheduler #(
  parameter int NBITS          = 16,
  parameter int F_WIDTH        = 20,
  parameter int TAG_WIDTH      = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NBITS*F_WIDTH-1:0]   v_features,
  input  logic                       v_valid,
  output logic                       v_ready,
  input  logic [NBITS*F_WIDTH-1:0]   a_features,
  input  logic                       a_valid,
  output logic                       a_ready,
  output logic [NBITS*F_WIDTH-1:0]   svm_features,
  output logic                       svm_fin_valid,
  input  logic                       svm_fin_ready,
  input  logic                       svm_valence,
  input  logic                       svm_arousal,
  input  logic                       svm_dout_valid,
  output logic                       svm_dout_ready,
  output logic                       out_valence,
  output logic                       out_arousal,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic [CNT_WIDTH-1:0]       out_latency,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int FW = NBITS * F_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_V,
    S_SEND_A,
    S_WAIT_RES,
    S_OUT
  } state_t;

  state_t                 state_q;
  logic [FW-1:0]          v_buf_q;
  logic [FW-1:0]          a_buf_q;
  logic                   v_full_q;
  logic                   a_full_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   res_val_q;
  logic                   res_aro_q;
  logic [TAG_WIDTH-1:0]   res_tag_q;
  logic [CNT_WIDTH-1:0]   res_lat_q;

`ifdef SVM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]        wd_q;
  logic                   err_q;
  assign out_err = err_q;
`else
  logic                   unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign out_err        = 1'b0;
`endif

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Readiness comes only from the registered flags, so a buffer freed this cycle refills next cycle.
  assign v_ready        = !v_full_q;
  assign a_ready        = !a_full_q;
  assign svm_fin_valid  = (state_q == S_SEND_V) || (state_q == S_SEND_A);
  assign svm_features   = (state_q == S_SEND_A) ? a_buf_q : v_buf_q;
  assign svm_dout_ready = (state_q == S_WAIT_RES);
  assign out_valid      = (state_q == S_OUT);
  assign busy           = (state_q != S_IDLE);
  assign out_valence    = res_val_q;
  assign out_arousal    = res_aro_q;
  assign out_tag        = res_tag_q;
  assign out_latency    = res_lat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      v_buf_q   <= '0;
      a_buf_q   <= '0;
      v_full_q  <= 1'b0;
      a_full_q  <= 1'b0;
      tag_q     <= '0;
      cnt_q     <= '0;
      res_val_q <= 1'b0;
      res_aro_q <= 1'b0;
      res_tag_q <= '0;
      res_lat_q <= '0;
`ifdef SVM_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      if (v_valid && !v_full_q) begin
        v_buf_q  <= v_features;
        v_full_q <= 1'b1;
      end
      if (a_valid && !a_full_q) begin
        a_buf_q  <= a_features;
        a_full_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (v_full_q && a_full_q) begin
            state_q <= S_SEND_V;
            cnt_q   <= '0;
          end
        end
        S_SEND_V: begin
          cnt_q <= cnt_d;
          if (svm_fin_ready) begin
            v_full_q <= 1'b0;
            state_q  <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          cnt_q <= cnt_d;
          if (svm_fin_ready) begin
            a_full_q <= 1'b0;
            state_q  <= S_WAIT_RES;
`ifdef SVM_TIMEOUT_EN
            wd_q     <= '0;
`endif
          end
        end
        S_WAIT_RES: begin
          cnt_q <= cnt_d;
          if (svm_dout_valid) begin
            res_val_q <= svm_valence;
            res_aro_q <= svm_arousal;
            res_tag_q <= tag_q;
            res_lat_q <= cnt_q;
            state_q   <= S_OUT;
`ifdef SVM_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
`ifdef SVM_TIMEOUT_EN
          // A silent SVM still yields an entry so the tag sequence stays gap-free.
          else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            res_val_q <= 1'b0;
            res_aro_q <= 1'b0;
            res_tag_q <= tag_q;
            res_lat_q <= '1;
            err_q     <= 1'b1;
            state_q   <= S_OUT;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            tag_q   <= tag_q + TAG_WIDTH'(1);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_modality_scheduler.sv
// tb/tb_svm_modality_scheduler.sv - self-checking bench for svm_modality_scheduler
// Build with SVM_TIMEOUT_EN defined to also exercise the watchdog path.
module tb_svm_modality_scheduler;

  localparam int NB = 16;
  localparam int NF = 20;
  localparam int W  = NB * NF;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] v_features = '0;
  logic         v_valid = 1'b0;
  logic         v_ready;
  logic [W-1:0] a_features = '0;
  logic         a_valid = 1'b0;
  logic         a_ready;
  logic [W-1:0] svm_features;
  logic         svm_fin_valid;
  logic         svm_fin_ready = 1'b1;
  logic         svm_valence = 1'b0;
  logic         svm_arousal = 1'b0;
  logic         svm_dout_valid = 1'b0;
  logic         svm_dout_ready;
  logic         out_valence;
  logic         out_arousal;
  logic [7:0]   out_tag;
  logic [15:0]  out_latency;
  logic         out_err;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;

  always #5 clk = ~clk;

  svm_modality_scheduler #(
    .NBITS(NB), .F_WIDTH(NF), .TAG_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .v_features(v_features), .v_valid(v_valid), .v_ready(v_ready),
    .a_features(a_features), .a_valid(a_valid), .a_ready(a_ready),
    .svm_features(svm_features), .svm_fin_valid(svm_fin_valid), .svm_fin_ready(svm_fin_ready),
    .svm_valence(svm_valence), .svm_arousal(svm_arousal),
    .svm_dout_valid(svm_dout_valid), .svm_dout_ready(svm_dout_ready),
    .out_valence(out_valence), .out_arousal(out_arousal), .out_tag(out_tag),
    .out_latency(out_latency), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // SVM behaviour knobs, set by the stimulus process
  int   cfg_stall = 0;
  int   cfg_delay = 3;
  logic cfg_lv = 1'b1;
  logic cfg_la = 1'b0;
  bit   cfg_mute = 1'b0;

  // Reference model state
  int           cyc = 0;
  bit           m_vfull, m_afull;
  logic [W-1:0] m_vbuf, m_abuf;
  int           hs_n;
  bit           in_entry;
  int           issue_c;
  int           stall_left;
  bit           pend;
  int           resp_at;
  int           wd_n;
  bit           exp_have;
  logic         exp_val, exp_aro, exp_err;
  logic [7:0]   exp_tag;
  logic [15:0]  exp_lat;
  logic [7:0]   m_tag;

  always @(negedge clk) begin
    bit v_cap, a_cap;
    cyc++;
    if (rst) begin
      m_vfull = 0; m_afull = 0; m_vbuf = '0; m_abuf = '0;
      hs_n = 0; in_entry = 0; stall_left = 0; pend = 0; wd_n = 0;
      exp_have = 0; m_tag = 8'd0;
      svm_fin_ready = 1'b1;
      svm_dout_valid = 1'b0;
    end else begin
      chk("v_ready", 64'(v_ready), 64'(!m_vfull));
      chk("a_ready", 64'(a_ready), 64'(!m_afull));
      v_cap = v_valid && !m_vfull;
      a_cap = a_valid && !m_afull;

      if (out_valid) begin
        chk("out_valid_expected", 64'(exp_have), 64'd1);
        chk("out_valence", 64'(out_valence), 64'(exp_val));
        chk("out_arousal", 64'(out_arousal), 64'(exp_aro));
        chk("out_tag", 64'(out_tag), 64'(exp_tag));
        chk("out_latency", 64'(out_latency), 64'(exp_lat));
        chk("out_err", 64'(out_err), 64'(exp_err));
        if (out_ready) begin
          exp_have = 0;
          m_tag = m_tag + 8'd1;
          in_entry = 0;
          hs_n = 0;
        end
      end

      if (svm_fin_valid) begin
        if (!in_entry) begin
          in_entry = 1;
          issue_c = cyc;
          stall_left = cfg_stall;
        end
        chk("issue_count", 64'(hs_n < 2), 64'd1);
        if (hs_n == 0) chkv("svm_features_v", svm_features, m_vbuf);
        else           chkv("svm_features_a", svm_features, m_abuf);
        svm_fin_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (svm_fin_ready) begin
          if (hs_n == 0) m_vfull = 0;
          else begin
            m_afull = 0;
            pend = 1;
            resp_at = cyc + cfg_delay;
            wd_n = 0;
          end
          hs_n++;
        end
      end else begin
        svm_fin_ready = 1'b1;
      end

      svm_valence = cfg_lv;
      svm_arousal = cfg_la;
      svm_dout_valid = pend && !cfg_mute && (cyc >= resp_at);
      if (svm_dout_valid && svm_dout_ready) begin
        exp_have = 1;
        exp_val = cfg_lv;
        exp_aro = cfg_la;
        exp_tag = m_tag;
        exp_lat = (cyc - issue_c > 65535) ? 16'hFFFF : 16'(cyc - issue_c);
        exp_err = 1'b0;
        pend = 0;
      end
`ifdef SVM_TIMEOUT_EN
      else if (svm_dout_ready && cfg_mute && pend) begin
        wd_n++;
        if (wd_n == TMO) begin
          exp_have = 1;
          exp_val = 1'b0;
          exp_aro = 1'b0;
          exp_tag = m_tag;
          exp_lat = 16'hFFFF;
          exp_err = 1'b1;
          pend = 0;
        end
      end
`endif

      if (v_cap) begin m_vfull = 1; m_vbuf = v_features; end
      if (a_cap) begin m_afull = 1; m_abuf = a_features; end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] v, input logic [W-1:0] a, input bit dv, input bit da);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if ((!dv || v_ready) && (!da || a_ready)) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("send_ready_wait", 64'(ok), 64'd1);
    v_features = v; a_features = a;
    v_valid = dv; a_valid = da;
    @(posedge clk); #1;
    v_valid = 1'b0; a_valid = 1'b0;
  endtask

  task automatic wait_out(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("wait_out_valid", 64'(ok), 64'd1);
  endtask

  logic [W-1:0] ones, twos, pat;

  initial begin
    ones = {NF{16'd1}};
    twos = {NF{16'd2}};
    for (int j = 0; j < NF; j++) pat[j*NB +: NB] = 16'(j * 3 + 5);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_v_ready", 64'(v_ready), 64'd1);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fin_valid", 64'(svm_fin_valid), 64'd0);
    chk("rst_dout_ready", 64'(svm_dout_ready), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_latency", 64'(out_latency), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chkv("rst_svm_features", svm_features, '0);

    // 1: both vectors together, result three cycles after the arousal handshake
    @(posedge clk); #1;
    send(ones, twos, 1, 1);
    wait_out(60);
    chk("t1_valence", 64'(out_valence), 64'd1);
    chk("t1_arousal", 64'(out_arousal), 64'd0);
    chk("t1_tag", 64'(out_tag), 64'd0);
    chk("t1_latency", 64'(out_latency), 64'd4);

    // 2: arousal alone must not start the sequence
    do_reset();
    send(pat, twos, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_busy", 64'(busy), 64'd0);
      chk("t2_fin_valid", 64'(svm_fin_valid), 64'd0);
      chk("t2_a_ready", 64'(a_ready), 64'd0);
    end
    @(posedge clk); #1;
    cfg_lv = 1'b0; cfg_la = 1'b1;
    send(pat, twos, 1, 0);
    wait_out(60);
    chk("t2_tag", 64'(out_tag), 64'd0);
    chk("t2_latency", 64'(out_latency), 64'd4);
    chk("t2_arousal", 64'(out_arousal), 64'd1);

    // 3: SVM back-pressure on the valence issue
    do_reset();
    cfg_stall = 5; cfg_lv = 1'b1; cfg_la = 1'b1;
    send(pat, ones, 1, 1);
    wait_out(60);
    chk("t3_latency", 64'(out_latency), 64'd9);
    cfg_stall = 0;

    // 4: downstream stall while both buffers refill, then tag wrap
    do_reset();
    cfg_lv = 1'b1; cfg_la = 1'b0;
    out_ready = 1'b0;
    send(ones, twos, 1, 1);
    wait_out(60);
    @(posedge clk); #1;
    send(pat, ones, 1, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_tag", 64'(out_tag), 64'd0);
      chk("t4_hold_latency", 64'(out_latency), 64'd4);
      chk("t4_v_ready", 64'(v_ready), 64'd0);
      chk("t4_a_ready", 64'(a_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    wait_out(60);
    chk("t4_next_tag", 64'(out_tag), 64'd1);
    for (int k = 2; k < 256; k++) begin
      cfg_lv = k[0]; cfg_la = k[1];
      send(pat ^ W'(k), ones ^ W'(k * 7), 1, 1);
      wait_out(60);
    end
    send(ones, twos, 1, 1);
    wait_out(60);
    chk("t4_wrap_tag", 64'(out_tag), 64'd0);

    // 5: reset while waiting for the SVM result
    do_reset();
    cfg_delay = 30;
    send(ones, twos, 1, 1);
    begin
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (svm_dout_ready) begin ok = 1; break; end
      end
      chk("t5_reach_wait", 64'(ok), 64'd1);
    end
    do_reset();
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_v_ready", 64'(v_ready), 64'd1);
    chk("t5_a_ready", 64'(a_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_dout_ready", 64'(svm_dout_ready), 64'd0);
    cfg_delay = 3;
    @(posedge clk); #1;
    send(pat, twos, 1, 1);
    wait_out(60);
    chk("t5_tag", 64'(out_tag), 64'd0);
    chk("t5_latency", 64'(out_latency), 64'd4);

`ifdef SVM_TIMEOUT_EN
    // 6: SVM never answers
    do_reset();
    cfg_mute = 1'b1;
    send(ones, twos, 1, 1);
    wait_out(80);
    chk("t6_err", 64'(out_err), 64'd1);
    chk("t6_valence", 64'(out_valence), 64'd0);
    chk("t6_arousal", 64'(out_arousal), 64'd0);
    chk("t6_latency", 64'(out_latency), 64'hFFFF);
    chk("t6_tag", 64'(out_tag), 64'd0);
    cfg_mute = 1'b0; cfg_lv = 1'b1; cfg_la = 1'b1;
    @(posedge clk); #1;
    send(pat, ones, 1, 1);
    wait_out(60);
    chk("t6_err_clear", 64'(out_err), 64'd0);
    chk("t6_next_tag", 64'(out_tag), 64'd1);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/svm_modality_scheduler.md
Name: svm_modality_scheduler

Overview:
Sequences the shared SVM classifier core across the two modalities. It buffers one valence and one arousal feature vector from independent upstream producers. It issues them to the SVM strictly in the order valence then arousal, captures the joint valence/arousal result, and returns it downstream with an entry tag and a measured cycle latency. It sits between the feature-extraction front end and the SVM, and replaces the alternating-modality sequencing logic that the host would otherwise need.

Parameters:
NBITS, 16, bits per signed feature
F_WIDTH, 20, features per vector
TAG_WIDTH, 8, entry tag width (wraps)
CNT_WIDTH, 16, latency counter width (saturating)
TIMEOUT_CYCLES, 4096, watchdog limit (used only with SVM_TIMEOUT_EN)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset; synchronous, active-high
v_features  in  NBITS*F_WIDTH  valence vector, feature j at [j*NBITS +: NBITS]
v_valid  in  1  valence vector valid
v_ready  out  1  valence buffer empty
a_features  in  NBITS*F_WIDTH  arousal vector, same packing
a_valid  in  1  arousal vector valid
a_ready  out  1  arousal buffer empty
svm_features  out  NBITS*F_WIDTH  to SVM in_features
svm_fin_valid  out  1  to SVM fin_valid
svm_fin_ready  in  1  from SVM fin_ready
svm_valence  in  1  from SVM valence
svm_arousal  in  1  from SVM arousal
svm_dout_valid  in  1  from SVM dout_valid
svm_dout_ready  out  1  to SVM dout_ready
out_valence  out  1  result valence label
out_arousal  out  1  result arousal label
out_tag  out  TAG_WIDTH  entry index of result
out_latency  out  CNT_WIDTH  cycles from valence issue to result capture
out_err  out  1  timeout flag (0 when feature disabled)
out_valid  out  1  result valid
out_ready  in  1  downstream accept
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0, except v_ready=1 and a_ready=1. Buffers empty, tag counter 0, FSM in IDLE.
- Input buffers:
  - v_ready = !v_full, where v_full is a registered flag. A v_valid&&v_ready beat captures v_features into v_buf and sets v_full on the next edge.
  - The arousal side is identical with a_ready, a_buf and a_full.
  - No same-cycle refill: ready is derived only from the registered flag.
- FSM states: IDLE, SEND_V, SEND_A, WAIT_RES, OUT.
  - IDLE -> SEND_V when v_full && a_full. The latency counter clears to 0 on this transition.
  - SEND_V: svm_fin_valid=1, svm_features=v_buf. On svm_fin_valid&&svm_fin_ready, clear v_full and go to SEND_A.
  - SEND_A: svm_fin_valid=1, svm_features=a_buf. On the handshake, clear a_full and go to WAIT_RES.
  - WAIT_RES: svm_dout_ready=1. On svm_dout_valid, register svm_valence/svm_arousal, out_tag=tag counter and out_latency=counter value. Then go to OUT.
  - OUT: out_valid=1, with outputs held stable until out_ready. On acceptance, tag counter increments (wraps at 2^TAG_WIDTH) and the FSM goes to IDLE.
- svm_fin_valid is low in all states other than SEND_V/SEND_A. svm_dout_ready is low outside WAIT_RES.
- svm_features holds v_buf whenever the FSM is not in SEND_A.
- svm_fin_valid must not drop while waiting for svm_fin_ready.
- Refill: once SEND_V or SEND_A frees a buffer, the producer may refill it during the rest of the entry. The next entry can then start on the cycle after OUT completes.
- Latency counter: increments every cycle in SEND_V, SEND_A and WAIT_RES. It saturates at 2^CNT_WIDTH-1. The capture value equals the number of cycles spent in those three states minus 1.
- Simultaneous events:
  - v and a may both arrive in the same cycle.
  - If v_full becomes set while a is already full, the IDLE transition happens on the cycle after the set.
  - svm_dout_valid outside WAIT_RES is ignored (dout_ready is 0).
- Reset mid-operation: rst overrides all state on the edge. The in-flight entry is discarded, buffers empty, tag returns to 0, no partial out_valid. The SVM shares rst.

Optional Feature:
SVM_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_RES. When the count reaches TIMEOUT_CYCLES without svm_dout_valid, the FSM goes to OUT with out_err=1, out_valence=0, out_arousal=0 and out_latency saturated. The tag still consumes a value.
- out_err clears when the next result is captured.
- Undefined: no watchdog logic, out_err is tied 0, and WAIT_RES waits indefinitely.

Test Plan:
1. Reset, then present v=vector all 1s and a=vector all 2s in the same cycle, with the SVM model returning valence=1, arousal=0 three cycles after the arousal handshake -> svm_features shows the v vector then the a vector on successive handshakes; out_valid with out_valence=1, out_arousal=0, out_tag=0, out_latency=4.
2. Present a only; hold v for 10 cycles -> busy stays 0, svm_fin_valid stays 0 and a_ready=0 until v arrives; the sequence then starts V first.
3. SVM holds svm_fin_ready=0 for 5 cycles in SEND_V -> svm_fin_valid held at 1 with stable svm_features; out_latency increases by 5 versus scenario 1.
4. Hold out_ready=0 for 7 cycles while the producer refills both buffers -> outputs stable, v_ready=a_ready=0; after acceptance the next entry starts with out_tag=1. Run 256 entries -> tag wraps back to 0.
5. Assert rst in WAIT_RES -> next cycle: busy=0, v_ready=a_ready=1, out_valid=0; the next entry reports out_tag=0.
6. With SVM_TIMEOUT_EN and TIMEOUT_CYCLES=16, the SVM never asserts dout_valid -> after 16 WAIT_RES cycles out_valid=1, out_err=1, labels 0; the following good entry has out_err=0, out_tag=1.
